// File: rtl/divideby_n_fsm_pkg.sv
// Shared types for the programmable clock divider.
//   statetype : divider run state (idle / running)
//   modetype  : output waveform selection (single-cycle pulse / near-50% square)
package divider_pkg;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } statetype;

    typedef enum logic {
        MODE_PULSE,
        MODE_SQUARE
    } modetype;

endpackage

// File: rtl/divideby_n_fsm_if.sv
// Control/status bundle for divideby_n_fsm.
//   en         : run enable (master -> slave)
//   load       : sample div_i this cycle (master -> slave)
//   div_i      : requested divisor, 0 treated as 1 (master -> slave)
//   mode       : MODE_PULSE / MODE_SQUARE (master -> slave)
//   y          : divided output (slave -> master)
//   tick       : last cycle of each period (slave -> master)
//   div_active : divisor currently in effect (slave -> master)
interface divideby_n_fsm_if #(
    parameter int unsigned WIDTH = 8
);
    import divider_pkg::*;

    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_i;
    modetype          mode;
    logic             y;
    logic             tick;
    logic [WIDTH-1:0] div_active;

    modport master (
        output en,
        output load,
        output div_i,
        output mode,
        input  y,
        input  tick,
        input  div_active
    );

    modport slave (
        input  en,
        input  load,
        input  div_i,
        input  mode,
        output y,
        output tick,
        output div_active
    );

endinterface

// File: rtl/divideby_n_fsm.sv
// Runtime-programmable clock divider / timing-strobe generator.
// Divides clk by N (1..2^WIDTH-1), emitting a one-cycle pulse or a near-50% square wave,
// plus a tick in the last cycle of every period. Divisor reloads while running are held in
// a shadow register and applied only at a period boundary so no short/long period occurs.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : divideby_n_fsm_if.slave (en, load, div_i, mode -> y, tick, div_active)
module divideby_n_fsm
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic            clk,
    input  logic            reset,
    divideby_n_fsm_if.slave bus
);

    statetype         state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_shadow_q, div_shadow_d;
    logic             pend_q, pend_d;

    logic [WIDTH-1:0] div_norm;
    logic             last;
    logic             wrap;
    logic [WIDTH:0]   half;

    // A zero divisor would never wrap; treat it as divide-by-1.
    assign div_norm = (bus.div_i == '0) ? WIDTH'(1) : bus.div_i;

    // div_act is never 0, so the subtraction cannot underflow.
    assign last = (cnt_q == div_act_q - WIDTH'(1));
    assign wrap = (state_q == S_RUN) && bus.en && last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            div_act_q    <= WIDTH'(DEFAULT_DIV);
            div_shadow_q <= WIDTH'(DEFAULT_DIV);
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_act_q    <= div_act_d;
            div_shadow_q <= div_shadow_d;
            pend_q       <= pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_act_d    = div_act_q;
        div_shadow_d = div_shadow_q;
        pend_d       = pend_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.load) begin
                    div_act_d = div_norm;
                end
                if (bus.en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (last) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end

                // A load on the wrap edge takes effect directly; otherwise it waits in
                // the shadow register so the running period finishes with the old divisor.
                if (bus.load && wrap) begin
                    div_act_d = div_norm;
                    pend_d    = 1'b0;
                end else if (bus.load) begin
                    div_shadow_d = div_norm;
                    pend_d       = 1'b1;
                end else if (wrap && pend_q) begin
                    div_act_d = div_shadow_q;
                    pend_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ceil(N/2), computed one bit wider so N = 2^WIDTH-1 does not overflow.
    assign half = ({1'b0, div_act_q} + (WIDTH+1)'(1)) >> 1;

    always_comb begin
        bus.y    = 1'b0;
        bus.tick = 1'b0;
        if (state_q == S_RUN) begin
            bus.tick = last;
            if (bus.mode == MODE_SQUARE) begin
                bus.y = ({1'b0, cnt_q} < half);
            end else begin
                bus.y = (cnt_q == '0);
            end
        end
    end

    assign bus.div_active = div_act_q;

endmodule

// File: tb/tb_divideby_n_fsm.sv
module tb_divideby_n_fsm;
    import divider_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    divideby_n_fsm_if #(.WIDTH(WIDTH)) bus ();

    divideby_n_fsm #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ey, input logic et,
                           input logic [7:0] ediv);
        chk({tag, ".y"}, {31'b0, bus.y}, {31'b0, ey});
        chk({tag, ".tick"}, {31'b0, bus.tick}, {31'b0, et});
        chk({tag, ".div"}, {24'b0, bus.div_active}, {24'b0, ediv});
    endtask

    initial begin
        logic [5:0] py3, pt3;
        logic [9:0] sy5, st5;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        bus.en     = 1'b0;
        bus.load   = 1'b0;
        bus.div_i  = '0;
        bus.mode   = MODE_PULSE;
        #2;
        chk_out("reset", 1'b0, 1'b0, 8'd3);
        step();
        reset = 1'b0;
        step();
        chk_out("idle_after_reset", 1'b0, 1'b0, 8'd3);

        // Default N=3, pulse mode
        py3 = 6'b100100;
        pt3 = 6'b001001;
        bus.en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("n3_pulse[%0d]", i), {31'b0, bus.y}, {31'b0, py3[5-i]});
            chk($sformatf("n3_tick[%0d]", i), {31'b0, bus.tick}, {31'b0, pt3[5-i]});
        end
        chk("n3_div", {24'b0, bus.div_active}, 32'd3);

        // Load 5 in idle, square mode
        bus.en = 1'b0;
        step();
        chk_out("idle_n3", 1'b0, 1'b0, 8'd3);
        bus.mode  = MODE_SQUARE;
        bus.load  = 1'b1;
        bus.div_i = 8'd5;
        step();
        bus.load = 1'b0;
        chk_out("idle_load5", 1'b0, 1'b0, 8'd5);
        sy5 = 10'b11100_11100;
        st5 = 10'b00001_00001;
        bus.en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("n5_sq[%0d]", i), {31'b0, bus.y}, {31'b0, sy5[9-i]});
            chk($sformatf("n5_tick[%0d]", i), {31'b0, bus.tick}, {31'b0, st5[9-i]});
        end

        // N=4 running, load 2 at cnt=1: period finishes at 4, then 2
        bus.en = 1'b0;
        step();
        bus.load  = 1'b1;
        bus.div_i = 8'd4;
        step();
        bus.load = 1'b0;
        bus.mode = MODE_PULSE;
        bus.en   = 1'b1;
        step();
        chk_out("n4_c0", 1'b1, 1'b0, 8'd4);
        step();
        chk_out("n4_c1", 1'b0, 1'b0, 8'd4);
        bus.load  = 1'b1;
        bus.div_i = 8'd2;
        step();
        bus.load = 1'b0;
        chk_out("n4_c2_pend", 1'b0, 1'b0, 8'd4);
        step();
        chk_out("n4_c3", 1'b0, 1'b1, 8'd4);
        step();
        chk_out("n2_c0", 1'b1, 1'b0, 8'd2);
        step();
        chk_out("n2_c1", 1'b0, 1'b1, 8'd2);
        step();
        chk_out("n2_c0b", 1'b1, 1'b0, 8'd2);
        step();
        chk_out("n2_c1b", 1'b0, 1'b1, 8'd2);
        // Load on the wrap edge goes straight in
        bus.load  = 1'b1;
        bus.div_i = 8'd3;
        step();
        bus.load = 1'b0;
        chk_out("wrapload_c0", 1'b1, 1'b0, 8'd3);
        step();
        chk_out("wrapload_c1", 1'b0, 1'b0, 8'd3);
        step();
        chk_out("wrapload_c2", 1'b0, 1'b1, 8'd3);

        // Divisor 0 -> 1
        bus.en = 1'b0;
        step();
        bus.load  = 1'b1;
        bus.div_i = 8'd0;
        step();
        bus.load = 1'b0;
        chk_out("div0_idle", 1'b0, 1'b0, 8'd1);
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("n1_pulse[%0d]", i), 1'b1, 1'b1, 8'd1);
        end
        bus.mode = MODE_SQUARE;
        #1;
        chk_out("n1_sq_now", 1'b1, 1'b1, 8'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk_out($sformatf("n1_sq[%0d]", i), 1'b1, 1'b1, 8'd1);
        end

        // N=6: drop en at cnt=2, re-raise 3 cycles later
        bus.en = 1'b0;
        step();
        bus.load  = 1'b1;
        bus.div_i = 8'd6;
        step();
        bus.load = 1'b0;
        bus.mode = MODE_PULSE;
        bus.en   = 1'b1;
        step();
        chk_out("n6_c0", 1'b1, 1'b0, 8'd6);
        step();
        step();
        chk_out("n6_c2", 1'b0, 1'b0, 8'd6);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("n6_idle[%0d]", i), 1'b0, 1'b0, 8'd6);
        end
        bus.en = 1'b1;
        step();
        chk_out("n6_restart_c0", 1'b1, 1'b0, 8'd6);
        step();
        chk_out("n6_restart_c1", 1'b0, 1'b0, 8'd6);

        // Async reset mid-period with a pending load of 7
        bus.load  = 1'b1;
        bus.div_i = 8'd7;
        step();
        bus.load = 1'b0;
        chk_out("pend7", 1'b0, 1'b0, 8'd6);
        #2;
        reset  = 1'b1;
        bus.en = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 1'b0, 8'd3);
        step();
        reset = 1'b0;
        step();
        chk_out("post_reset_idle", 1'b0, 1'b0, 8'd3);
        bus.en = 1'b1;
        step();
        chk_out("post_reset_c0", 1'b1, 1'b0, 8'd3);
        step();
        step();
        chk_out("post_reset_c2", 1'b0, 1'b1, 8'd3);
        step();
        chk_out("post_reset_wrap", 1'b1, 1'b0, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
